wf_issue_dispatch: RTL and testbench

- Sits directly downstream of the round-robin wavefront arbiter.
- Latches the arbiter's chosen wavefront and presents it to the functional-unit issue port with a valid/ready handshake.
- Generates the issued_en/issued_wf_id pulse the arbiter uses to rotate priority.
- Keeps a 40-entry busy bitmap so a wavefront with an in-flight instruction is masked out of the arbiter's request vector until its completion returns.

---
 rtl/wf_issue_dispatch.sv | 109 ++++++++++
 tb/tb_wf_issue_dispatch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wf_issue_dispatch.sv
// wf_issue_dispatch: holds the arbiter's chosen wavefront, offers it to the
// functional-unit issue port over valid/ready, pulses issued_en on handshake,
// and tracks which wavefronts have an instruction in flight so the arbiter
// never sees a request from a busy or currently held wavefront.
module wf_issue_dispatch #(
  parameter int NUM_WF  = 40,
  parameter int WF_ID_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_WF-1:0]  ready_arry,
  output logic [NUM_WF-1:0]  masked_ready_arry,
  input  logic               choosen_valid,
  input  logic [WF_ID_W-1:0] choosen_wf_id,
  output logic               fu_valid,
  output logic [WF_ID_W-1:0] fu_wf_id,
  input  logic               fu_ready,
  output logic               issued_en,
  output logic [WF_ID_W-1:0] issued_wf_id,
  input  logic               done_en,
  input  logic [WF_ID_W-1:0] done_wf_id,
  output logic [NUM_WF-1:0]  busy_arry
);

  // Slot count widened by one bit so ids up to 2**WF_ID_W-1 compare cleanly.
  localparam logic [WF_ID_W:0] NUM_WF_L = (WF_ID_W+1)'(NUM_WF);

  // IDLE: nothing held. HOLD: pending_id_q is being offered to the FU.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WF_ID_W-1:0]  pending_id_q, pending_id_d;
  logic [NUM_WF-1:0]   busy_q, busy_d;
  logic [NUM_WF-1:0]   pending_mask;
  logic                choose_ok;
  logic                done_ok;

  // Out-of-range ids (NUM_WF..2**WF_ID_W-1) are treated as absent.
  assign choose_ok = choosen_valid && ({1'b0, choosen_wf_id} < NUM_WF_L);
  assign done_ok   = done_en && ({1'b0, done_wf_id} < NUM_WF_L);

  assign fu_valid     = (state_q == HOLD);
  assign fu_wf_id     = fu_valid ? pending_id_q : '0;
  assign issued_en    = fu_valid && fu_ready;
  assign issued_wf_id = fu_valid ? pending_id_q : '0;
  assign busy_arry    = busy_q;

  // One-hot of the held wavefront, so the arbiter cannot pick it again while it waits.
  always_comb begin
    pending_mask = '0;
    if (state_q == HOLD) begin
      pending_mask[pending_id_q] = 1'b1;
    end
  end

  assign masked_ready_arry = ready_arry & ~busy_q & ~pending_mask;

  // Next-state: load/hold/release the pending slot and update the busy bitmap.
  always_comb begin
    state_d      = state_q;
    pending_id_d = pending_id_q;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        if (choose_ok) begin
          state_d      = HOLD;
          pending_id_d = choosen_wf_id;
        end
      end
      HOLD: begin
        // Under backpressure the held id is frozen and new choices are ignored.
        if (fu_ready) begin
          if (choose_ok) begin
            pending_id_d = choosen_wf_id;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear first, then set, so a same-id collision leaves the bit set.
    if (done_ok) begin
      busy_d[done_wf_id] = 1'b0;
    end
    if (issued_en) begin
      busy_d[pending_id_q] = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_id_q <= '0;
      busy_q       <= '0;
    end else begin
      state_q      <= state_d;
      pending_id_q <= pending_id_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_wf_issue_dispatch.sv
// Bench for wf_issue_dispatch: directed scenarios plus random traffic, all
// compared against a slot-level reference model (array of busy flags and a
// single "held id or -1" integer).
module tb_wf_issue_dispatch;

  localparam int NUM_WF  = 40;
  localparam int WF_ID_W = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic [NUM_WF-1:0]  ready_arry;
  logic [NUM_WF-1:0]  masked_ready_arry;
  logic               choosen_valid;
  logic [WF_ID_W-1:0] choosen_wf_id;
  logic               fu_valid;
  logic [WF_ID_W-1:0] fu_wf_id;
  logic               fu_ready;
  logic               issued_en;
  logic [WF_ID_W-1:0] issued_wf_id;
  logic               done_en;
  logic [WF_ID_W-1:0] done_wf_id;
  logic [NUM_WF-1:0]  busy_arry;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_busy [NUM_WF];
  int m_pend = -1;

  wf_issue_dispatch #(.NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .ready_arry        (ready_arry),
    .masked_ready_arry (masked_ready_arry),
    .choosen_valid     (choosen_valid),
    .choosen_wf_id     (choosen_wf_id),
    .fu_valid          (fu_valid),
    .fu_wf_id          (fu_wf_id),
    .fu_ready          (fu_ready),
    .issued_en         (issued_en),
    .issued_wf_id      (issued_wf_id),
    .done_en           (done_en),
    .done_wf_id        (done_wf_id),
    .busy_arry         (busy_arry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model predicts for the current inputs.
  task automatic check_model();
    logic [NUM_WF-1:0] exp_busy;
    logic [NUM_WF-1:0] exp_mask;
    bit hold;
    hold = (m_pend >= 0);
    for (int i = 0; i < NUM_WF; i++) begin
      exp_busy[i] = m_busy[i];
      exp_mask[i] = ready_arry[i] && !m_busy[i] && !(hold && i == m_pend);
    end
    chk("fu_valid", 64'(fu_valid), 64'(hold));
    chk("fu_wf_id", 64'(fu_wf_id), hold ? 64'(m_pend) : 64'd0);
    chk("issued_en", 64'(issued_en), 64'(hold && fu_ready));
    chk("issued_wf_id", 64'(issued_wf_id), hold ? 64'(m_pend) : 64'd0);
    chk("busy_arry", 64'(busy_arry), 64'(exp_busy));
    chk("masked_ready_arry", 64'(masked_ready_arry), 64'(exp_mask));
  endtask

  // Drive one cycle of inputs away from the active edge, then check the model.
  task automatic drive(input logic r, input logic [NUM_WF-1:0] rdy, input logic cv,
                       input int cid, input logic fur, input logic den, input int did);
    @(negedge clk);
    rst           = r;
    ready_arry    = rdy;
    choosen_valid = cv;
    choosen_wf_id = WF_ID_W'(cid);
    fu_ready      = fur;
    done_en       = den;
    done_wf_id    = WF_ID_W'(did);
    #1;
    check_model();
  endtask

  // Advance to the clock edge and apply the same rules to the model.
  task automatic tick();
    bit hold;
    bit legal_c;
    bit legal_d;
    int cid;
    int did;
    @(posedge clk);
    cid     = int'(choosen_wf_id);
    did     = int'(done_wf_id);
    legal_c = choosen_valid && cid < NUM_WF;
    legal_d = done_en && did < NUM_WF;
    hold    = (m_pend >= 0);
    if (rst) begin
      m_pend = -1;
      for (int i = 0; i < NUM_WF; i++) m_busy[i] = 1'b0;
    end else begin
      if (legal_d) m_busy[did] = 1'b0;
      if (hold && fu_ready) m_busy[m_pend] = 1'b1;
      if (!hold) begin
        if (legal_c) m_pend = cid;
      end else if (fu_ready) begin
        m_pend = legal_c ? cid : -1;
      end
    end
  endtask

  localparam logic [NUM_WF-1:0] ALL = '1;

  initial begin
    rst = 1'b1; ready_arry = '0; choosen_valid = 1'b0; choosen_wf_id = '0;
    fu_ready = 1'b0; done_en = 1'b0; done_wf_id = '0;

    // Reset and first issue of id 0
    drive(1, 40'h1, 0, 0, 0, 0, 0); tick();
    drive(0, 40'h1, 1, 0, 1, 0, 0);
    chk("rst_fu_valid", 64'(fu_valid), 64'd0);
    chk("rst_busy", 64'(busy_arry), 64'd0);
    chk("rst_masked", 64'(masked_ready_arry), 64'h1);
    tick();
    drive(0, 40'h1, 0, 0, 1, 0, 0);
    chk("tp1_fu_valid", 64'(fu_valid), 64'd1);
    chk("tp1_issued_en", 64'(issued_en), 64'd1);
    chk("tp1_issued_id", 64'(issued_wf_id), 64'd0);
    tick();
    drive(0, 40'h1, 0, 0, 0, 0, 0);
    chk("tp1_busy", 64'(busy_arry), 64'h1);
    chk("tp1_masked", 64'(masked_ready_arry), 64'h0);
    tick();

    // Backpressure: hold 5 while 7 is offered
    drive(0, ALL, 1, 5, 0, 0, 0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(0, ALL, 1, 7, 0, 0, 0);
      chk("bp_fu_wf_id", 64'(fu_wf_id), 64'd5);
      chk("bp_issued_en", 64'(issued_en), 64'd0);
      chk("bp_mask5", 64'(masked_ready_arry[5]), 64'd0);
      tick();
    end
    drive(0, ALL, 1, 7, 1, 0, 0);
    chk("bp_release_id", 64'(issued_wf_id), 64'd5);
    tick();
    drive(0, ALL, 0, 0, 1, 0, 0);
    chk("bp_next_id", 64'(fu_wf_id), 64'd7);
    tick();

    // Back-to-back 1,2,3
    drive(1, ALL, 0, 0, 0, 0, 0); tick();
    drive(0, ALL, 1, 1, 1, 0, 0); tick();
    for (int k = 1; k <= 3; k++) begin
      drive(0, ALL, k < 3, k + 1, 1, 0, 0);
      chk("b2b_issued_en", 64'(issued_en), 64'd1);
      chk("b2b_issued_id", 64'(issued_wf_id), 64'(k));
      tick();
    end
    drive(0, ALL, 0, 0, 0, 0, 0);
    chk("b2b_busy", 64'(busy_arry), 64'hE);
    tick();

    // Completion of 39, spurious completion of 12
    drive(0, ALL, 1, 39, 1, 0, 0); tick();
    drive(0, ALL, 0, 0, 1, 0, 0); tick();
    drive(0, ALL, 0, 0, 0, 1, 39);
    chk("done_busy39_before", 64'(busy_arry[39]), 64'd1);
    tick();
    drive(0, ALL, 0, 0, 0, 1, 12);
    chk("done_busy39_after", 64'(busy_arry[39]), 64'd0);
    chk("done_masked39", 64'(masked_ready_arry[39]), 64'd1);
    tick();
    drive(0, ALL, 0, 0, 0, 0, 0);
    chk("done_nonbusy", 64'(busy_arry), 64'hE);
    tick();

    // Same-id set/clear collision, then illegal choice
    drive(0, ALL, 1, 9, 1, 0, 0); tick();
    drive(0, ALL, 0, 0, 1, 1, 9); tick();
    drive(0, ALL, 1, 45, 1, 0, 0);
    chk("collide_busy", 64'(busy_arry), 64'h20E);
    tick();
    drive(0, ALL, 0, 0, 1, 1, 50);
    chk("illegal_fu_valid", 64'(fu_valid), 64'd0);
    tick();

    // Mid-operation reset with pending 4 and busy FF
    drive(1, ALL, 0, 0, 0, 0, 0); tick();
    for (int k = 0; k < 8; k++) begin
      drive(0, ALL, 1, k, 1, 0, 0); tick();
    end
    drive(0, ALL, 0, 0, 1, 0, 0); tick();
    drive(0, ALL, 1, 4, 0, 0, 0); tick();
    drive(0, ALL, 0, 0, 0, 0, 0);
    chk("mr_pending4", 64'(fu_wf_id), 64'd4);
    chk("mr_busyFF", 64'(busy_arry), 64'hFF);
    tick();
    drive(1, ALL, 0, 0, 0, 0, 0); tick();
    drive(0, ALL, 0, 0, 1, 0, 0);
    chk("mr_fu_valid", 64'(fu_valid), 64'd0);
    chk("mr_busy", 64'(busy_arry), 64'd0);
    chk("mr_issued_en", 64'(issued_en), 64'd0);
    tick();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [NUM_WF-1:0] rdy;
      rdy = {8'($urandom), $urandom};
      drive(($urandom_range(0, 99) == 0), rdy, 1'($urandom), $urandom_range(0, 47),
            ($urandom_range(0, 3) != 0), 1'($urandom), $urandom_range(0, 47));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
